// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard shot sequencer.
package billiard_pkg;

    localparam int unsigned SPEED_W = 11;
    localparam int unsigned POWER_W = 6;
    localparam int unsigned AIM_W   = 3;

    typedef enum logic [2:0] {
        ST_AIM,
        ST_CHARGE,
        ST_FIRE,
        ST_ROLLING,
        ST_SETTLE
    } state_t;

    // Unit direction vector; each component is -1, 0 or +1, Y positive downward.
    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } dir_t;

    // Aim code to direction: E, NE, N, NW, W, SW, S, SE.
    function automatic dir_t dir_lookup(input logic [AIM_W-1:0] code);
        dir_t d;
        d.dx = 2'sd0;
        d.dy = 2'sd0;
        case (code)
            3'd0: begin d.dx =  2'sd1; d.dy =  2'sd0; end
            3'd1: begin d.dx =  2'sd1; d.dy = -2'sd1; end
            3'd2: begin d.dx =  2'sd0; d.dy = -2'sd1; end
            3'd3: begin d.dx = -2'sd1; d.dy = -2'sd1; end
            3'd4: begin d.dx = -2'sd1; d.dy =  2'sd0; end
            3'd5: begin d.dx = -2'sd1; d.dy =  2'sd1; end
            3'd6: begin d.dx =  2'sd0; d.dy =  2'sd1; end
            default: begin d.dx = 2'sd1; d.dy = 2'sd1; end
        endcase
        return d;
    endfunction

    // Apply a unit direction component to an unsigned speed magnitude.
    function automatic logic signed [SPEED_W-1:0] scale_axis(
        input logic signed [1:0]   unit,
        input logic [SPEED_W-1:0]  mag
    );
        logic signed [SPEED_W-1:0] r;
        r = '0;
        if (unit == 2'sd1)
            r = $signed(mag);
        else if (unit == -2'sd1)
            r = $signed(SPEED_W'(0) - mag);
        return r;
    endfunction

endpackage

// File: rtl/power_ramp.sv
// Saturating, frame-gated shot power counter with synchronous clear.
module power_ramp #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned MAX_VAL = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             frame,
    output logic [WIDTH-1:0] value
);

    // Clear wins over counting; counting stops at MAX_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (enable && frame && (value < WIDTH'(MAX_VAL)))
            value <= value + WIDTH'(1);
    end

endmodule

// File: rtl/shot_sequencer.sv
// Shot sequencer: aim, charge power, launch the cue ball, wait for the table
// to settle and decide the next player.
// Optional feature: define SHOT_TIMEOUT_EN to abort long rolls with forceStop
// after ROLL_TIMEOUT frames.
module shot_sequencer
    import billiard_pkg::*;
#(
    parameter int unsigned NUM_BALLS     = 4,
    parameter int unsigned MAX_POWER     = 63,
    parameter int unsigned SPEED_SCALE   = 4,
    parameter int unsigned SETTLE_FRAMES = 15,
    parameter int unsigned ROLL_TIMEOUT  = 1023
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      shootKey,
    input  logic [AIM_W-1:0]          aimDir,
    input  logic [NUM_BALLS-1:0]      ballMoving,
    input  logic                      cuePocketed,
    input  logic                      ballPocketed,
    output logic                      launchPulse,
    output logic signed [SPEED_W-1:0] launchXspeed,
    output logic signed [SPEED_W-1:0] launchYspeed,
    output logic [POWER_W-1:0]        power,
    output logic                      playerTurn,
    output logic                      turnDone,
    output logic                      foul,
    output logic                      respawnCue,
    output logic                      forceStop
);

    localparam int unsigned SET_W = $clog2(SETTLE_FRAMES + 1);

    state_t                    state_q, state_d;
    logic [AIM_W-1:0]          aim_q, aim_d;
    logic [SET_W-1:0]          settle_q, settle_d;
    logic                      scratch_q, scratch_d;
    logic                      object_q, object_d;
    logic                      player_d;
    logic                      launch_d, turn_done_d, foul_d, respawn_d;
    logic signed [SPEED_W-1:0] xs_d, ys_d;
    logic                      clear_power, charge_en;
    logic                      end_turn, scratch_now, object_now;
    logic                      timeout_c;
    logic [SPEED_W-1:0]        mag;
    dir_t                      dir;

    power_ramp #(
        .WIDTH   (POWER_W),
        .MAX_VAL (MAX_POWER)
    ) u_power_ramp (
        .clk    (clk),
        .rst    (resetN),
        .clear  (clear_power),
        .enable (charge_en),
        .frame  (startOfFrame),
        .value  (power)
    );

    assign mag = SPEED_W'(power) * SPEED_W'(SPEED_SCALE);
    assign dir = dir_lookup(aim_q);

`ifdef SHOT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(ROLL_TIMEOUT + 1);

    logic [TO_W-1:0] timer_q;
    logic            in_play;

    assign in_play   = (state_q == ST_ROLLING) || (state_q == ST_SETTLE);
    assign timeout_c = in_play && startOfFrame && ((timer_q + TO_W'(1)) == TO_W'(ROLL_TIMEOUT));

    // Frames spent rolling/settling; idle at zero outside play.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            timer_q <= '0;
        else if (!in_play || timeout_c)
            timer_q <= '0;
        else if (startOfFrame)
            timer_q <= timer_q + TO_W'(1);
    end

    // Abort strobe to the movers, aligned with the turn-end pulses.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            forceStop <= 1'b0;
        else
            forceStop <= timeout_c;
    end
`else
    // Timeout limit has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (ROLL_TIMEOUT == 0);
    assign timeout_c = 1'b0;
    assign forceStop = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q      <= ST_AIM;
            aim_q        <= '0;
            settle_q     <= '0;
            scratch_q    <= 1'b0;
            object_q     <= 1'b0;
            playerTurn   <= 1'b0;
            launchPulse  <= 1'b0;
            launchXspeed <= '0;
            launchYspeed <= '0;
            turnDone     <= 1'b0;
            foul         <= 1'b0;
            respawnCue   <= 1'b0;
        end else begin
            state_q      <= state_d;
            aim_q        <= aim_d;
            settle_q     <= settle_d;
            scratch_q    <= scratch_d;
            object_q     <= object_d;
            playerTurn   <= player_d;
            launchPulse  <= launch_d;
            launchXspeed <= xs_d;
            launchYspeed <= ys_d;
            turnDone     <= turn_done_d;
            foul         <= foul_d;
            respawnCue   <= respawn_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        aim_d       = aim_q;
        settle_d    = settle_q;
        scratch_d   = scratch_q;
        object_d    = object_q;
        player_d    = playerTurn;
        launch_d    = 1'b0;
        xs_d        = '0;
        ys_d        = '0;
        turn_done_d = 1'b0;
        foul_d      = 1'b0;
        respawn_d   = 1'b0;
        clear_power = 1'b0;
        charge_en   = 1'b0;
        end_turn    = 1'b0;
        scratch_now = scratch_q | cuePocketed;
        object_now  = object_q | ballPocketed;

        case (state_q)
            ST_AIM: begin
                if (shootKey) begin
                    state_d     = ST_CHARGE;
                    aim_d       = aimDir;
                    clear_power = 1'b1;
                end
            end
            ST_CHARGE: begin
                // A release on a frame edge suppresses that frame's increment.
                charge_en = shootKey;
                if (!shootKey)
                    state_d = ST_FIRE;
            end
            ST_FIRE: begin
                if (power != '0) begin
                    launch_d = 1'b1;
                    xs_d     = scale_axis(dir.dx, mag);
                    ys_d     = scale_axis(dir.dy, mag);
                    settle_d = '0;
                    state_d  = ST_ROLLING;
                end else begin
                    state_d = ST_AIM;
                end
            end
            ST_ROLLING: begin
                scratch_d = scratch_now;
                object_d  = object_now;
                if (startOfFrame && (ballMoving == '0)) begin
                    settle_d = SET_W'(1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                scratch_d = scratch_now;
                object_d  = object_now;
                if (startOfFrame) begin
                    if (|ballMoving) begin
                        settle_d = '0;
                        state_d  = ST_ROLLING;
                    end else if ((settle_q + SET_W'(1)) >= SET_W'(SETTLE_FRAMES)) begin
                        end_turn = 1'b1;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
            end
            default: state_d = ST_AIM;
        endcase

        if (timeout_c)
            end_turn = 1'b1;

        // Turn end: scratch beats a pocketed object ball, otherwise turn passes.
        if (end_turn) begin
            state_d     = ST_AIM;
            settle_d    = '0;
            scratch_d   = 1'b0;
            object_d    = 1'b0;
            turn_done_d = 1'b1;
            if (scratch_now) begin
                foul_d    = 1'b1;
                respawn_d = 1'b1;
                player_d  = ~playerTurn;
            end else if (!object_now) begin
                player_d = ~playerTurn;
            end
        end
    end

endmodule

// File: tb/tb_shot_sequencer.sv
// Scoreboard bench for shot_sequencer: expected launches and turn endings are
// queued when stimulus is driven and checked when the DUT strobes them.
module tb_shot_sequencer;

    localparam int unsigned NB = 4;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame;
    logic              shootKey;
    logic [2:0]        aimDir;
    logic [NB-1:0]     ballMoving;
    logic              cuePocketed;
    logic              ballPocketed;
    logic              launchPulse;
    logic signed [10:0] launchXspeed;
    logic signed [10:0] launchYspeed;
    logic [5:0]        power;
    logic              playerTurn;
    logic              turnDone;
    logic              foul;
    logic              respawnCue;
    logic              forceStop;

    typedef struct {
        int x;
        int y;
        int p;
    } launch_t;

    typedef struct {
        int foul_exp;
        int player;
        int force_stop;
    } turn_t;

    launch_t launch_q[$];
    turn_t   turn_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_launch = 0;
    int n_done   = 0;
    int exp_player = 0;

    int dx_tab[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int dy_tab[8] = '{0, -1, -1, -1, 0, 1, 1, 1};

    shot_sequencer dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .shootKey     (shootKey),
        .aimDir       (aimDir),
        .ballMoving   (ballMoving),
        .cuePocketed  (cuePocketed),
        .ballPocketed (ballPocketed),
        .launchPulse  (launchPulse),
        .launchXspeed (launchXspeed),
        .launchYspeed (launchYspeed),
        .power        (power),
        .playerTurn   (playerTurn),
        .turnDone     (turnDone),
        .foul         (foul),
        .respawnCue   (respawnCue),
        .forceStop    (forceStop)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick(1);
            startOfFrame = 1'b0;
            tick(3);
        end
    endtask

    task automatic expect_launch(input int aim, input int p);
        launch_t e;
        e.x = dx_tab[aim] * p * 4;
        e.y = dy_tab[aim] * p * 4;
        e.p = p;
        launch_q.push_back(e);
    endtask

    task automatic expect_turn(input int is_foul, input int obj, input int frc);
        turn_t e;
        if (is_foul != 0 || obj == 0)
            exp_player = 1 - exp_player;
        e.foul_exp   = is_foul;
        e.player     = exp_player;
        e.force_stop = frc;
        turn_q.push_back(e);
    endtask

    // Aim, hold shootKey for n frames, release between frames.
    task automatic shoot(input int aim, input int n);
        int p;
        p = (n > 63) ? 63 : n;
        aimDir   = 3'(aim);
        shootKey = 1'b1;
        tick(2);
        frames(n);
        if (p > 0)
            expect_launch(aim, p);
        shootKey = 1'b0;
        tick(4);
    endtask

    // Compare DUT strobes against the scoreboard.
    always @(negedge clk) begin : monitor
        launch_t le;
        turn_t   te;
        if (launchPulse) begin
            n_launch++;
            if (launch_q.size() == 0) begin
                check_eq("unexpected_launch", 1, 0);
            end else begin
                le = launch_q.pop_front();
                check_eq("launch_x", launchXspeed, le.x);
                check_eq("launch_y", launchYspeed, le.y);
                check_eq("launch_power", power, le.p);
            end
        end
        if (turnDone) begin
            n_done++;
            if (turn_q.size() == 0) begin
                check_eq("unexpected_turn_done", 1, 0);
            end else begin
                te = turn_q.pop_front();
                check_eq("turn_foul", foul, te.foul_exp);
                check_eq("turn_respawn", respawnCue, te.foul_exp);
                check_eq("turn_player", playerTurn, te.player);
                check_eq("turn_force_stop", forceStop, te.force_stop);
                check_eq("turn_speed_idle", launchXspeed, 0);
            end
        end
    end

    initial begin
        resetN       = 1'b1;
        startOfFrame = 1'b0;
        shootKey     = 1'b0;
        aimDir       = 3'd0;
        ballMoving   = '0;
        cuePocketed  = 1'b0;
        ballPocketed = 1'b0;
        tick(3);
        check_eq("rst_power", power, 0);
        check_eq("rst_player", playerTurn, 0);
        check_eq("rst_launch", launchPulse, 0);
        check_eq("rst_turn_done", turnDone, 0);
        check_eq("rst_xspeed", launchXspeed, 0);
        check_eq("rst_force_stop", forceStop, 0);
        resetN = 1'b0;
        tick(2);

        // East, 10 frames; settle interrupted by one moving frame.
        shoot(0, 10);
        check_eq("a_launch_count", n_launch, 1);
        check_eq("a_power_hold", power, 10);
        check_eq("a_speed_idle", launchXspeed, 0);
        frames(14);
        check_eq("a_no_early_done", n_done, 0);
        ballMoving = 4'b0100;
        frames(1);
        ballMoving = '0;
        frames(14);
        check_eq("a_no_done_before_15", n_done, 0);
        expect_turn(0, 0, 0);
        frames(1);
        tick(2);
        check_eq("a_done_count", n_done, 1);
        check_eq("a_player", playerTurn, 1);
        check_eq("a_power_after_turn", power, 10);

        // North, saturating power; scratch plus object pocket while rolling.
        ballMoving = 4'b0001;
        shoot(2, 100);
        check_eq("b_launch_count", n_launch, 2);
        check_eq("b_power_sat", power, 63);
        frames(3);
        cuePocketed  = 1'b1;
        ballPocketed = 1'b1;
        tick(1);
        cuePocketed  = 1'b0;
        ballPocketed = 1'b0;
        frames(2);
        ballMoving = '0;
        frames(14);
        expect_turn(1, 1, 0);
        frames(1);
        tick(2);
        check_eq("b_done_count", n_done, 2);
        check_eq("b_player", playerTurn, 0);

        // Tap between frames: no launch, back in AIM.
        shootKey = 1'b1;
        tick(2);
        shootKey = 1'b0;
        tick(4);
        check_eq("c_no_launch", n_launch, 2);
        check_eq("c_power_zero", power, 0);
        check_eq("c_launch_low", launchPulse, 0);

        // Pocket in AIM is ignored; SW shot pots an object ball, turn kept.
        cuePocketed = 1'b1;
        tick(1);
        cuePocketed = 1'b0;
        shoot(5, 3);
        check_eq("d_launch_count", n_launch, 3);
        ballPocketed = 1'b1;
        tick(1);
        ballPocketed = 1'b0;
        frames(14);
        expect_turn(0, 1, 0);
        frames(1);
        tick(2);
        check_eq("d_done_count", n_done, 3);
        check_eq("d_player_kept", playerTurn, 0);

        // SE, release coincides with a frame edge: that frame does not count.
        aimDir   = 3'd7;
        shootKey = 1'b1;
        tick(2);
        frames(5);
        expect_launch(7, 5);
        startOfFrame = 1'b1;
        shootKey     = 1'b0;
        tick(1);
        startOfFrame = 1'b0;
        tick(4);
        check_eq("e_launch_count", n_launch, 4);
        check_eq("e_power", power, 5);
        frames(14);
        expect_turn(0, 0, 0);
        frames(1);
        tick(2);
        check_eq("e_player", playerTurn, 1);

        // Asynchronous reset while charging.
        aimDir   = 3'd1;
        shootKey = 1'b1;
        tick(2);
        frames(20);
        check_eq("r_power_charged", power, 20);
        #2;
        resetN = 1'b1;
        #1;
        check_eq("r_power_async", power, 0);
        check_eq("r_player_async", playerTurn, 0);
        check_eq("r_launch_async", launchPulse, 0);
        check_eq("r_turn_done_async", turnDone, 0);
        shootKey   = 1'b0;
        exp_player = 0;
        tick(2);
        resetN = 1'b0;
        tick(6);
        check_eq("r_no_launch_release", n_launch, 4);
        check_eq("r_power_after", power, 0);

        // West shot with balls stuck moving.
        ballMoving = 4'b0001;
        shoot(4, 2);
        check_eq("t_launch_count", n_launch, 5);
`ifdef SHOT_TIMEOUT_EN
        frames(1022);
        check_eq("t_no_early_timeout", n_done, 4);
        expect_turn(0, 0, 1);
        frames(1);
        tick(2);
        check_eq("t_timeout_done", n_done, 5);
        ballMoving = '0;
`else
        frames(40);
        check_eq("t_waits", n_done, 4);
        check_eq("t_force_stop_low", forceStop, 0);
        ballMoving = '0;
        frames(14);
        expect_turn(0, 0, 0);
        frames(1);
        tick(2);
        check_eq("t_settle_done", n_done, 5);
`endif

        tick(4);
        check_eq("launch_queue_empty", launch_q.size(), 0);
        check_eq("turn_queue_empty", turn_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter NUM_BALLS, default 4: number of balls monitored for motion.
REQ-002 Parameter MAX_POWER, default 63: saturation value of the shot power counter.
REQ-003 Parameter SPEED_SCALE, default 4: launch speed per power unit, in 1/64-pixel-per-frame units.
REQ-004 Parameter SETTLE_FRAMES, default 15: consecutive all-stopped frames required to end a turn.
REQ-005 Parameter ROLL_TIMEOUT, default 1023: frame limit in ROLLING (used only with SHOT_TIMEOUT_EN).
REQ-006 Port clk, input, 1: single clock.
REQ-007 Port resetN, input, 1: asynchronous, active-high reset.
REQ-008 Port startOfFrame, input, 1: one-cycle pulse per video frame.
REQ-009 Port shootKey, input, 1: level; high while the player holds the shoot key.
REQ-010 Port aimDir, input, 3: aim direction code 0..7 (E, NE, N, NW, W, SW, S, SE).
REQ-011 Port ballMoving, input, NUM_BALLS: per-ball nonzero-speed flag; bit 0 is the cue ball.
REQ-012 Port cuePocketed, input, 1: one-cycle pulse; cue ball entered a pocket.
REQ-013 Port ballPocketed, input, 1: one-cycle pulse; an object ball entered a pocket.
REQ-014 Port launchPulse, output, 1: one-cycle strobe; cue-ball mover loads launch speeds.
REQ-015 Port launchXspeed / launchYspeed, output, 11 signed each: launch velocity, held valid while launchPulse is high.
REQ-016 Port power, output, 6: current power level, for the power-bar display.
REQ-017 Port playerTurn, output, 1: active player (0 or 1).
REQ-018 Port turnDone, foul, respawnCue, output, 1 each: one-cycle end-of-turn pulses.
REQ-019 Port forceStop, output, 1: one-cycle pulse commanding all movers to zero their speeds.

Function
REQ-020 FSM states: AIM, CHARGE, FIRE, ROLLING, SETTLE.
- AIM -> CHARGE on shootKey high.
- aimDir is latched on that same cycle.
- power is cleared on that same cycle.
REQ-021 CHARGE behaviour:
- Each startOfFrame with shootKey high increments power by 1, saturating at MAX_POWER.
- shootKey low -> FIRE.
- If shootKey falls in the same cycle as startOfFrame, the release wins and power does not increment.
REQ-022 FIRE lasts exactly one cycle.
- If power > 0: assert launchPulse, then go to ROLLING.
- If power == 0: no pulse, return to AIM.
REQ-023 Launch speed = dx*power*SPEED_SCALE and dy*power*SPEED_SCALE.
- (dx,dy) come from the latched direction; each is in {-1,0,+1}.
- Y is positive downward; code N gives dy = -1.
- Products are computed at 11-bit signed width; the maximum magnitude, 252, does not overflow.
REQ-024 launchXspeed and launchYspeed read 0 whenever launchPulse is low.
REQ-025 ROLLING -> SETTLE on a startOfFrame with ballMoving == 0.
- The ROLLING -> SETTLE transition loads settle count = 1.
REQ-026 SETTLE behaviour, evaluated on each startOfFrame:
- Any ballMoving bit high: clear the count and return to ROLLING.
- Otherwise increment the count.
- When the count reaches SETTLE_FRAMES, go to AIM.
REQ-027 Pocket events:
- cuePocketed or ballPocketed seen in ROLLING or SETTLE sets a sticky flag.
- Both flags clear on AIM entry.
- Pocket pulses seen in AIM, CHARGE or FIRE are ignored.
REQ-028 On the SETTLE->AIM transition, pulse turnDone, then apply the first matching case:
- Scratch flag set: pulse foul and respawnCue, and toggle playerTurn.
- Else object flag set: playerTurn unchanged.
- Else: toggle playerTurn.
REQ-029 power holds its final value from FIRE until the next CHARGE entry.

Reset
REQ-030 Reset asserted at any time, including mid-shot, takes effect asynchronously:
- state = AIM, power = 0, playerTurn = 0, counters and flags cleared.
- All pulse outputs and speed outputs = 0.
- No launchPulse is generated on reset release.

Configuration
REQ-031 Macro SHOT_TIMEOUT_EN, when defined:
- A frame counter runs in ROLLING and SETTLE.
- When it reaches ROLL_TIMEOUT, pulse forceStop and go directly to AIM.
- turnDone and the REQ-028 decision apply, using the current flags.
REQ-032 Without SHOT_TIMEOUT_EN:
- ROLLING waits indefinitely.
- forceStop is tied to 0.
- No timeout counter is synthesized.

Structure
REQ-033 Package billiard_pkg holds:
- the FSM state enum;
- the 8-entry direction table (dx, dy);
- the speed width constant (11).
REQ-034 Sub-module power_ramp implements the saturating, frame-gated power counter with clear and enable inputs.

Verification
REQ-035 Aim code 0, hold shootKey for 10 frames, release -> one launchPulse with X=+40 and Y=0, power=10.
REQ-036 Aim code 2, hold for 100 frames -> power saturates at 63, launch X=0 and Y=-252.
REQ-037 Press and release shootKey between frames -> no launchPulse, FSM returns to AIM.
REQ-038 After a launch, ballMoving=0 for 14 frames, then bit 2 high for 1 frame, then 0 for 15 frames -> turnDone only after the second run of 15 frames, playerTurn toggles.
REQ-039 cuePocketed pulse during ROLLING together with ballPocketed -> at settle: foul, respawnCue and turnDone pulses, playerTurn toggles.
REQ-040 Assert resetN during CHARGE with power=20 -> immediately power=0, state AIM, outputs 0; with SHOT_TIMEOUT_EN and ballMoving stuck high -> forceStop after 1023 frames.
